// File: rtl/cpu_controller.sv
// Multi-cycle control FSM for a small register-file CPU; state advances on the falling clock edge.
// Define CPU_CTRL_XOR_EN to decode opcode 0101 as XOR, otherwise it executes as a NOP.
module cpu_controller (
  input  logic       CLKb,
  input  logic       RSTb,
  input  logic       Exec,
  input  logic [9:0] INSTR,
  output logic       IRin,
  output logic       ENW,
  output logic [1:0] WRA,
  output logic       ENR0,
  output logic [1:0] RDA0,
  output logic       ENR1,
  output logic [1:0] RDA1,
  output logic       Ain,
  output logic       Gin,
  output logic       Gout,
  output logic       Extern,
  output logic [1:0] ALUop,
  output logic       Done
);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  state_t     state;
  logic [9:0] ir;

  logic [1:0] rx;
  logic [1:0] ry;
  logic [3:0] op;
  logic       unused_ir;

  assign rx        = ir[9:8];
  assign ry        = ir[7:6];
  assign op        = ir[3:0];
  assign unused_ir = ^ir[5:4];

  logic       is_load;
  logic       is_copy;
  logic       is_alu;
  logic [1:0] alu_sel;

  always_comb begin
    is_load = 1'b0;
    is_copy = 1'b0;
    is_alu  = 1'b0;
    alu_sel = 2'b00;
    case (op)
      4'b0000: is_load = 1'b1;
      4'b0001: is_copy = 1'b1;
      4'b0010: begin
        is_alu  = 1'b1;
        alu_sel = 2'b00;
      end
      4'b0011: begin
        is_alu  = 1'b1;
        alu_sel = 2'b01;
      end
`ifdef CPU_CTRL_XOR_EN
      4'b0101: begin
        is_alu  = 1'b1;
        alu_sel = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  // Exec is only looked at in IDLE, so requests arriving mid-instruction are simply dropped.
  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Exec) begin
            ir    <= INSTR;
            state <= T1;
          end
        end
        T1:      state <= is_alu ? T2 : IDLE;
        T2:      state <= T3;
        T3:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    IRin   = (state == IDLE) && Exec && RSTb;
    ENW    = 1'b0;
    WRA    = 2'b00;
    ENR0   = 1'b0;
    RDA0   = 2'b00;
    ENR1   = 1'b0;
    RDA1   = 2'b00;
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    Extern = 1'b0;
    ALUop  = 2'b00;
    Done   = 1'b0;
    case (state)
      T1: begin
        if (is_load) begin
          Extern = 1'b1;
          ENW    = 1'b1;
          WRA    = rx;
          Done   = 1'b1;
        end else if (is_copy) begin
          ENR0 = 1'b1;
          RDA0 = ry;
          ENW  = 1'b1;
          WRA  = rx;
          Done = 1'b1;
        end else if (is_alu) begin
          ENR0 = 1'b1;
          RDA0 = rx;
          Ain  = 1'b1;
        end else begin
          Done = 1'b1;
        end
      end
      T2: begin
        ENR1  = 1'b1;
        RDA1  = ry;
        Gin   = 1'b1;
        ALUop = alu_sel;
      end
      T3: begin
        Gout = 1'b1;
        ENW  = 1'b1;
        WRA  = rx;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: an instruction-level model checked every cycle plus literal spot checks.
// Honours CPU_CTRL_XOR_EN the same way the design does.
module tb_cpu_controller;

  logic       CLKb;
  logic       RSTb;
  logic       Exec;
  logic [9:0] INSTR;
  logic       IRin, ENW, ENR0, ENR1, Ain, Gin, Gout, Extern, Done;
  logic [1:0] WRA, RDA0, RDA1, ALUop;

  int checks;
  int failures;

  cpu_controller dut (
    .CLKb(CLKb), .RSTb(RSTb), .Exec(Exec), .INSTR(INSTR),
    .IRin(IRin), .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .RDA0(RDA0),
    .ENR1(ENR1), .RDA1(RDA1), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .Extern(Extern), .ALUop(ALUop), .Done(Done)
  );

  initial CLKb = 1'b1;
  always #5 CLKb = ~CLKb;

  logic [16:0] dut_vec;
  assign dut_vec = {IRin, ENW, WRA, ENR0, RDA0, ENR1, RDA1, Ain, Gin, Gout, Extern, ALUop, Done};

  function automatic logic [16:0] pack(
    input logic irin, input logic enw, input logic [1:0] wra,
    input logic enr0, input logic [1:0] rda0, input logic enr1, input logic [1:0] rda1,
    input logic ain, input logic gin, input logic gout, input logic ext,
    input logic [1:0] aluop, input logic done);
    return {irin, enw, wra, enr0, rda0, enr1, rda1, ain, gin, gout, ext, aluop, done};
  endfunction

  localparam int K_LOAD = 0, K_COPY = 1, K_ALU = 2, K_NOP = 3;

  function automatic int kind_of(input logic [3:0] op);
    case (op)
      4'b0000: return K_LOAD;
      4'b0001: return K_COPY;
      4'b0010, 4'b0011: return K_ALU;
`ifdef CPU_CTRL_XOR_EN
      4'b0101: return K_ALU;
`endif
      default: return K_NOP;
    endcase
  endfunction

  function automatic logic [1:0] aluop_of(input logic [3:0] op);
    if (op == 4'b0011) return 2'b01;
    if (op == 4'b0101) return 2'b10;
    return 2'b00;
  endfunction

  // Instruction-level model: busy flag, the captured instruction and which of its cycles we are in.
  logic       m_busy = 1'b0;
  logic [9:0] m_ir   = '0;
  int         m_step = 0;

  always @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      m_busy = 1'b0;
      m_ir   = '0;
      m_step = 0;
    end else if (!m_busy) begin
      if (Exec) begin
        m_busy = 1'b1;
        m_ir   = INSTR;
        m_step = 1;
      end
    end else begin
      if (m_step == ((kind_of(m_ir[3:0]) == K_ALU) ? 3 : 1)) m_busy = 1'b0;
      else m_step = m_step + 1;
    end
  end

  function automatic logic [16:0] model_out();
    logic [1:0] rx, ry;
    int k;
    rx = m_ir[9:8];
    ry = m_ir[7:6];
    k  = kind_of(m_ir[3:0]);
    if (!RSTb) return '0;
    if (!m_busy) return pack(Exec, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
    if (k == K_LOAD) return pack(0, 1, rx, 0, 2'd0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 1);
    if (k == K_COPY) return pack(0, 1, rx, 1, ry, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1);
    if (k == K_NOP) return pack(0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1);
    if (m_step == 1) return pack(0, 0, 2'd0, 1, rx, 0, 2'd0, 1, 0, 0, 0, 2'd0, 0);
    if (m_step == 2) return pack(0, 0, 2'd0, 0, 2'd0, 1, ry, 0, 1, 0, 0, aluop_of(m_ir[3:0]), 0);
    return pack(0, 1, rx, 0, 2'd0, 0, 2'd0, 0, 0, 1, 0, 2'd0, 1);
  endfunction

  // Outputs settle after the falling edge, so the rising edge is a quiet point to compare.
  always @(posedge CLKb) begin
    logic [16:0] exp_vec;
    exp_vec = model_out();
    checks = checks + 1;
    if (dut_vec !== exp_vec) begin
      failures = failures + 1;
      $display("[TB] FAIL model_cycle t=%0t actual=%b required=%b", $time, dut_vec, exp_vec);
    end
  end

  task automatic checkOutput(input string name, input logic [16:0] actual, input logic [16:0] required);
    checks = checks + 1;
    if (actual !== required) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=%b required=%b", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [9:0] ins);
    Exec  = e;
    INSTR = ins;
    @(negedge CLKb);
    #2;
  endtask

  localparam logic [9:0] LOAD2 = 10'b10_00_00_0000;
  localparam logic [9:0] ADD12 = 10'b01_10_00_0010;
  localparam logic [9:0] SUB03 = 10'b00_11_00_0011;
  localparam logic [9:0] COPY31 = 10'b11_01_00_0001;
  localparam logic [9:0] XOR21 = 10'b10_01_00_0101;

  logic [9:0] extra [6] = '{10'b01_01_00_0010, 10'b10_10_00_0001, 10'b00_00_00_1111,
                            10'b11_00_00_0100, 10'b11_00_11_0000, 10'b10_11_00_0011};

  initial begin
    checks   = 0;
    failures = 0;
    RSTb     = 1'b0;
    Exec     = 1'b0;
    INSTR    = '0;
    repeat (2) @(negedge CLKb);
    #2;
    Exec  = 1'b1;
    INSTR = LOAD2;
    #1 checkOutput("reset_irin_masked", dut_vec, 17'd0);
    RSTb = 1'b1;
    Exec = 1'b0;
    #1 checkOutput("idle_after_reset", dut_vec, 17'd0);

    applyStimulus(1, LOAD2);
    #1 checkOutput("load_t1", dut_vec, pack(0, 1, 2'd2, 0, 2'd0, 0, 2'd0, 0, 0, 0, 1, 2'd0, 1));
    applyStimulus(0, '0);

    applyStimulus(1, ADD12);
    #1 checkOutput("add_t1", dut_vec, pack(0, 0, 2'd0, 1, 2'd1, 0, 2'd0, 1, 0, 0, 0, 2'd0, 0));
    applyStimulus(0, '0);
    #1 checkOutput("add_t2", dut_vec, pack(0, 0, 2'd0, 0, 2'd0, 1, 2'd2, 0, 1, 0, 0, 2'b00, 0));
    applyStimulus(0, '0);
    #1 checkOutput("add_t3", dut_vec, pack(0, 1, 2'd1, 0, 2'd0, 0, 2'd0, 0, 0, 1, 0, 2'd0, 1));
    applyStimulus(0, '0);

    applyStimulus(1, SUB03);
    applyStimulus(1, COPY31);
    #1 checkOutput("sub_t2", dut_vec, pack(0, 0, 2'd0, 0, 2'd0, 1, 2'd3, 0, 1, 0, 0, 2'b01, 0));
    applyStimulus(1, COPY31);
    #1 checkOutput("sub_t3", dut_vec, pack(0, 1, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 1, 0, 2'd0, 1));
    applyStimulus(1, COPY31);
    #1 checkOutput("b2b_irin", dut_vec, pack(1, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0));
    applyStimulus(1, COPY31);
    #1 checkOutput("copy_t1", dut_vec, pack(0, 1, 2'd3, 1, 2'd1, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1));
    applyStimulus(0, '0);

    applyStimulus(1, XOR21);
`ifdef CPU_CTRL_XOR_EN
    #1 checkOutput("xor_t1", dut_vec, pack(0, 0, 2'd0, 1, 2'd2, 0, 2'd0, 1, 0, 0, 0, 2'd0, 0));
    applyStimulus(0, '0);
    #1 checkOutput("xor_t2", dut_vec, pack(0, 0, 2'd0, 0, 2'd0, 1, 2'd1, 0, 1, 0, 0, 2'b10, 0));
    applyStimulus(0, '0);
    applyStimulus(0, '0);
`else
    #1 checkOutput("xor_as_nop", dut_vec, pack(0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1));
    applyStimulus(0, '0);
`endif

    applyStimulus(1, ADD12);
    applyStimulus(1, LOAD2);
    #1 checkOutput("drop_t2", dut_vec, pack(0, 0, 2'd0, 0, 2'd0, 1, 2'd2, 0, 1, 0, 0, 2'b00, 0));
    applyStimulus(1, COPY31);
    #1 checkOutput("drop_t3", dut_vec, pack(0, 1, 2'd1, 0, 2'd0, 0, 2'd0, 0, 0, 1, 0, 2'd0, 1));
    applyStimulus(0, '0);
    #1 checkOutput("drop_idle", dut_vec, 17'd0);

    applyStimulus(1, ADD12);
    applyStimulus(0, '0);
    #1 RSTb = 1'b0;
    #1 checkOutput("reset_mid_t2", dut_vec, 17'd0);
    applyStimulus(0, '0);
    RSTb = 1'b1;
    applyStimulus(0, '0);
    #1 checkOutput("post_reset_idle", dut_vec, 17'd0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, extra[i]);
      repeat (3) applyStimulus(0, '0);
    end
    applyStimulus(1, 10'b01_01_00_0010);
    applyStimulus(0, '0);
    #1 checkOutput("add_r1r1_t2", dut_vec, pack(0, 0, 2'd0, 0, 2'd0, 1, 2'd1, 0, 1, 0, 0, 2'b00, 0));
    repeat (3) applyStimulus(0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
